axis_rd_meter: RTL

AXIS_RD_METER -- requirements
Module: axis_rd_meter

---
 rtl/axis_rd_meter_pkg.sv | 21 ++
 rtl/axis_rd_meter_sat_counter.sv | 40 ++++
 rtl/axis_rd_meter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/axis_rd_meter_pkg.sv
// Shared types and helpers for the AXIS read meter.
package axis_rd_meter_pkg;

  // One-hot meter states.
  typedef enum logic [3:0] {
    StIdle = 4'b0001,
    StArm  = 4'b0010,
    StRun  = 4'b0100,
    StDone = 4'b1000
  } state_t;

  // Widest counter the saturating helper supports.
  localparam int unsigned SatMaxW = 64;

  // Increment that sticks at max instead of wrapping.
  function automatic logic [SatMaxW-1:0] sat_inc(input logic [SatMaxW-1:0] val,
                                                 input logic [SatMaxW-1:0] max);
    return (val >= max) ? val : val + SatMaxW'(1);
  endfunction

endpackage

// File: rtl/axis_rd_meter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
  import axis_rd_meter_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // All-ones at width W, computed in the helper's width (W = SatMaxW wraps to all-ones).
  localparam logic [SatMaxW-1:0] Max = (SatMaxW'(1) << W) - SatMaxW'(1);

  logic [W-1:0] q_q, q_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc) begin
      q_d = W'(sat_inc(SatMaxW'(q_q), Max));
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/axis_rd_meter.sv
// AXIS read meter: accepts LENGTH_REG beats after a START_REG level, counting beats and RUN
// cycles. Define AXIS_RD_METER_CHECK_EN to build the data checker (expected word for beat i is
// zero-extended SEED_REG + i); without it ERR_CNT_REG and FIRST_ERR_REG read 0.
module axis_rd_meter
  import axis_rd_meter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  s_axis_tready,
  input  logic                  START_REG,
  input  logic [31:0]           LENGTH_REG,
  input  logic [31:0]           SEED_REG,
  output logic                  BUSY_REG,
  output logic                  DONE_REG,
  output logic [CNT_WIDTH-1:0]  BEATS_REG,
  output logic [CNT_WIDTH-1:0]  CYCLES_REG,
  output logic [CNT_WIDTH-1:0]  ERR_CNT_REG,
  output logic [CNT_WIDTH-1:0]  FIRST_ERR_REG
);

  state_t               state_q, state_d;
  logic                 tready_q;
  logic [31:0]          len_q;
  logic                 arm, run;
  logic                 accept, last_beat;
  logic [CNT_WIDTH-1:0] beats;

  // tready is a flop that mirrors "next state is RUN", so it never depends on tvalid.
  assign s_axis_tready = tready_q;
  assign accept        = s_axis_tvalid & tready_q;
  assign last_beat     = accept && ((64'(beats) + 64'd1) == 64'(len_q));

  // State, tready and latched length registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      tready_q <= 1'b0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      tready_q <= (state_d == StRun);
      if (arm) begin
        len_q <= LENGTH_REG;
      end
    end
  end

  // Next-state logic; ARM decides on the length it is latching this cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (START_REG) state_d = StArm;
      StArm:   state_d = (LENGTH_REG == 32'd0) ? StDone : StRun;
      StRun:   if (last_beat) state_d = StDone;
      StDone:  if (!START_REG) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State-decoded outputs and counter controls.
  always_comb begin
    arm      = (state_q == StArm);
    run      = (state_q == StRun);
    BUSY_REG = arm | run;
    DONE_REG = (state_q == StDone);
  end

  sat_counter #(.W(CNT_WIDTH)) u_beats (
    .clk  (clk),
    .rstn (rstn),
    .clr  (arm),
    .inc  (accept),
    .q    (beats)
  );

  sat_counter #(.W(CNT_WIDTH)) u_cycles (
    .clk  (clk),
    .rstn (rstn),
    .clr  (arm),
    .inc  (run),
    .q    (CYCLES_REG)
  );

  assign BEATS_REG = beats;

`ifdef AXIS_RD_METER_CHECK_EN
  logic [DATA_WIDTH-1:0] seed_q;
  logic [DATA_WIDTH-1:0] expected;
  logic                  mismatch;
  logic                  err_seen_q;
  logic [CNT_WIDTH-1:0]  first_err_q;

  // Current beat count is the index of the beat being accepted.
  assign expected = seed_q + DATA_WIDTH'(beats);
  assign mismatch = accept && (s_axis_tdata != expected);

  // Seed latch and first-mismatch capture.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seed_q      <= '0;
      err_seen_q  <= 1'b0;
      first_err_q <= '0;
    end else if (arm) begin
      seed_q      <= DATA_WIDTH'(SEED_REG);
      err_seen_q  <= 1'b0;
      first_err_q <= '0;
    end else if (mismatch && !err_seen_q) begin
      err_seen_q  <= 1'b1;
      first_err_q <= beats;
    end
  end

  sat_counter #(.W(CNT_WIDTH)) u_errs (
    .clk  (clk),
    .rstn (rstn),
    .clr  (arm),
    .inc  (mismatch),
    .q    (ERR_CNT_REG)
  );

  assign FIRST_ERR_REG = first_err_q;
`else
  logic unused_chk;
  assign unused_chk    = ^{SEED_REG, s_axis_tdata};
  assign ERR_CNT_REG   = '0;
  assign FIRST_ERR_REG = '0;
`endif

endmodule
